mult4u_result_checker: RTL and testbench



---
 rtl/mult4u_result_checker.sv | 118 +++++++++++
 tb/tb_mult4u_result_checker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mult4u_result_checker.sv
// Golden-product checker for unsigned WIDTH-bit multipliers: recomputes a*b with a
// shift-add datapath, flags mismatches against the observed product, and keeps saturating stats.
module mult4u_result_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] dut_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_err,
  output logic               err_sticky,
  output logic [CNT_W-1:0]   err_count,
  input  logic               clr_count
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_dut_p;
  logic [CW-1:0]    r_step;
  logic [PW-1:0]    r_out_p;
  logic             r_out_err;
  logic             r_sticky;
  logic [CNT_W-1:0] r_count;

  logic [PW-1:0]    w_acc_nxt;
  logic             w_last;
  logic             w_err_nxt;
  logic             w_rec_err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_last    = (r_step == CW'(WIDTH - 1));
  assign w_err_nxt = (w_acc_nxt != r_dut_p);
  assign w_rec_err = (r_state == S_MUL) && w_last && w_err_nxt;

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign out_p      = r_out_p;
  assign out_err    = r_out_err;
  assign err_sticky = r_sticky;
  assign err_count  = r_count;

  // Sequencer and shift-add datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_dut_p   <= '0;
      r_step    <= '0;
      r_out_p   <= '0;
      r_out_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_dut_p  <= dut_p;
            r_acc    <= '0;
            r_step   <= '0;
            r_state  <= S_MUL;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_step   <= r_step + CW'(1);
          if (w_last) begin
            r_out_p   <= w_acc_nxt;
            r_out_err <= w_err_nxt;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Error statistics; a clear on the same edge as a recorded mismatch wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_sticky <= 1'b0;
    end else if (clr_count) begin
      r_count  <= '0;
      r_sticky <= 1'b0;
    end else if (w_rec_err) begin
      r_count  <= sat_inc(r_count);
      r_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mult4u_result_checker.sv
// Randomized self-checking bench for mult4u_result_checker; a CNT_W=2 copy exercises saturation.
module tb_mult4u_result_checker;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2*W-1:0] dut_p = '0;
  logic         out_ready = 1'b0;
  logic         clr_count = 1'b0;

  logic         in_ready, out_valid, out_err, err_sticky;
  logic [2*W-1:0] out_p;
  logic [15:0]  err_count;
  logic         in_ready2, out_valid2, out_err2, err_sticky2;
  logic [2*W-1:0] out_p2;
  logic [1:0]   err_count2;

  int n_chk = 0;
  int n_pass = 0;
  int m_cnt16 = 0;
  int m_cnt2 = 0;
  int m_sticky = 0;

  always #5 clk = ~clk;

  mult4u_result_checker #(.WIDTH(W), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .dut_p(dut_p), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_err(out_err), .err_sticky(err_sticky),
    .err_count(err_count), .clr_count(clr_count)
  );

  mult4u_result_checker #(.WIDTH(W), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .dut_p(dut_p), .out_valid(out_valid2), .out_ready(out_ready),
    .out_p(out_p2), .out_err(out_err2), .err_sticky(err_sticky2),
    .err_count(err_count2), .clr_count(clr_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic chk_stats();
    chk("err_count", 32'(err_count), 32'(m_cnt16));
    chk("err_count2", 32'(err_count2), 32'(m_cnt2));
    chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_count = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_count = 1'b0;
    m_cnt16 = 0; m_cnt2 = 0; m_sticky = 0;
    chk_stats();
  endtask

  // One transaction: hold = cycles of out_ready low once the result is up,
  // clr_done = raise clr_count on the edge the result is produced.
  task automatic run_txn(input int ta, input int tb, input int tp, input int hold, input bit clr_done);
    int e;
    int gold;
    bit mism;
    logic [2*W-1:0] held_p;
    gold = ta * tb;
    mism = (tp != gold);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a = W'(ta); b = W'(tb); dut_p = (2*W)'(tp);
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); dut_p = (2*W)'($urandom);
    e = 0;
    while (!out_valid && e < 20) begin
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      if (clr_done && e == W - 1) clr_count = 1'b1;
      @(posedge clk);
      e++;
      @(negedge clk);
      clr_count = 1'b0;
    end
    chk("latency", 32'(e), 32'(W));
    if (clr_done) begin
      m_cnt16 = 0; m_cnt2 = 0; m_sticky = 0;
    end else if (mism) begin
      m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : m_cnt16;
      m_cnt2  = (m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
      m_sticky = 1;
    end
    chk("out_p", 32'(out_p), 32'(gold));
    chk("out_err", 32'(out_err), 32'(mism));
    chk("out_p2", 32'(out_p2), 32'(gold));
    chk_stats();
    held_p = out_p;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_p", 32'(out_p), 32'(held_p));
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("consumed", 32'(out_valid), 32'd0);
    chk("in_ready_after", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_p", 32'(out_p), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk_stats();
    rst_n = 1'b1;

    run_txn(0, 0, 0, 0, 1'b0);
    run_txn(15, 15, 225, 0, 1'b0);
    run_txn(15, 15, 224, 0, 1'b0);
    run_txn(9, 7, 63, 10, 1'b0);

    // saturation of the 2-bit counter, then clear colliding with a mismatch
    pulse_clr();
    for (int i = 0; i < 5; i++) run_txn(i + 2, 3, 0, 0, 1'b0);
    run_txn(6, 6, 35, 0, 1'b1);
    chk("clr_out_err", 32'(out_err), 32'd1);

    pulse_clr();
    for (int i = 0; i < 256; i++) run_txn(i >> 4, i & 15, (i >> 4) * (i & 15), int'($urandom_range(0, 2)), 1'b0);

    for (int i = 0; i < 40; i++) begin
      int ra, rb, rp;
      ra = int'($urandom_range(0, 15));
      rb = int'($urandom_range(0, 15));
      rp = ($urandom_range(0, 1) == 0) ? ra * rb : int'($urandom_range(0, 255));
      run_txn(ra, rb, rp, int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    end
    run_txn(5, 5, 24, 0, 1'b0);

    // reset in the middle of a multiply
    @(negedge clk);
    in_valid = 1'b1; a = 4'd12; b = 4'd5; dut_p = 8'd60;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    m_cnt16 = 0; m_cnt2 = 0; m_sticky = 0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk_stats();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("dropped_valid", 32'(out_valid), 32'd0);
    end
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    run_txn(3, 4, 12, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
